stoch_eval_ctrl: RTL

STOCH_EVAL_CTRL -- requirements
Module: stoch_eval_ctrl

---
 rtl/stoch_pkg.sv | 35 +++
 rtl/stoch_eval_ctrl_if.sv | 25 ++
 rtl/stoch_phase_cnt.sv | 27 ++
 rtl/stoch_eval_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the stochastic evaluation controller.
// The WARMUP state exists only when STOCH_EVAL_WARMUP_EN is defined.
package stoch_pkg;

    localparam int DEF_LEN_W         = 16;
    localparam int DEF_CLEAR_CYCLES  = 2;
    localparam int DEF_WARMUP_CYCLES = 8;

`ifdef STOCH_EVAL_WARMUP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`endif

    // Phase counter must hold the largest of len-1, CLEAR_CYCLES-1 and WARMUP_CYCLES-1.
    function automatic int cnt_width(input int len_w, input int clr, input int wu);
        int w;
        w = len_w;
        if ($clog2(clr + 1) > w) w = $clog2(clr + 1);
        if ($clog2(wu + 1) > w)  w = $clog2(wu + 1);
        return w;
    endfunction

endpackage

// File: rtl/stoch_eval_ctrl_if.sv
// Host/datapath signal bundle of the evaluation controller; master = host and stream side, slave = controller.
interface stoch_eval_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic             bit_in;
    logic             dp_nRST;
    logic             dp_en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
    logic             valid;

    modport master (
        output start, abort, len, bit_in,
        input  dp_nRST, dp_en, busy, done, count, valid
    );

    modport slave (
        input  start, abort, len, bit_in,
        output dp_nRST, dp_en, busy, done, count, valid
    );
endinterface

// File: rtl/stoch_phase_cnt.sv
// Loadable down-counter shared by the CLEAR, WARMUP and RUN phases; zero flag is combinational from the count.
module stoch_phase_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/stoch_eval_ctrl.sv
// Runs one stochastic evaluation window: clears the datapath, optionally settles it (STOCH_EVAL_WARMUP_EN),
// then counts ones on bit_in for len cycles; all outputs are registered, abort wins over completion.
module stoch_eval_ctrl
    import stoch_pkg::*;
#(
    parameter int LEN_W         = DEF_LEN_W,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
    input  logic               CLK,
    input  logic               nRST,
    stoch_eval_ctrl_if.slave   bus
);

    localparam int CNT_W = cnt_width(LEN_W, CLEAR_CYCLES, WARMUP_CYCLES);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc;
    logic [LEN_W-1:0]   count_q;
    logic               valid_q;
    logic               done_q;
    logic               busy_q;
    logic               dp_en_q;
    logic               dp_nRST_q;

    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_val;

    stoch_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Each phase loads its length minus one, so zero marks the phase's last cycle.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
`ifdef STOCH_EVAL_WARMUP_EN
                    cnt_val  = CNT_W'(WARMUP_CYCLES - 1);
`else
                    cnt_val  = CNT_W'(len_q - 1'b1);
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef STOCH_EVAL_WARMUP_EN
            ST_WARMUP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(len_q - 1'b1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif
            ST_RUN:  cnt_dec = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            acc       <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dp_en_q   <= 1'b0;
            dp_nRST_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dp_nRST_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    busy_q  <= 1'b0;
                    dp_en_q <= 1'b0;
                    if (bus.start) begin
                        state     <= ST_CLEAR;
                        len_q     <= bus.len;
                        acc       <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        dp_nRST_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (!cnt_zero) begin
                        dp_nRST_q <= 1'b0;
                    end else if (len_q == '0) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= '0;
                        valid_q <= 1'b1;
                    end else begin
`ifdef STOCH_EVAL_WARMUP_EN
                        state   <= ST_WARMUP;
`else
                        state   <= ST_RUN;
`endif
                        dp_en_q <= 1'b1;
                    end
                end
`ifdef STOCH_EVAL_WARMUP_EN
                ST_WARMUP: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (cnt_zero) begin
                        state <= ST_RUN;
                    end
                end
`endif
                ST_RUN: begin
                    acc <= acc + LEN_W'(bus.bit_in);
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (cnt_zero) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= acc + LEN_W'(bus.bit_in);
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dp_nRST = dp_nRST_q;
    assign bus.dp_en   = dp_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.count   = count_q;
    assign bus.valid   = valid_q;

endmodule
